// File: rtl/shift_row_pkg.sv
// -----------------------------------------------------------------------------
// shift_row_pkg
// Shared AES definitions used by the round datapath blocks (ShiftRows,
// SubBytes, MixColumns):
//   - byte / state types (a state is 16 bytes, byte k = column*4 + row)
//   - row/column <-> byte index helpers
//   - forward and inverse ShiftRows source-index tables
// -----------------------------------------------------------------------------
package shift_row_pkg;

  localparam int STATE_W = 128;
  localparam int N_BYTES = 16;

  typedef logic [7:0] aes_byte_t;
  typedef aes_byte_t  aes_state_t [N_BYTES];

  // Byte index k = 4*c + r (column-major state layout).
  function automatic logic [1:0] byte_row(input logic [3:0] k);
    return k[1:0];
  endfunction

  function automatic logic [1:0] byte_col(input logic [3:0] k);
    return k[3:2];
  endfunction

  function automatic logic [3:0] byte_index(input logic [1:0] r, input logic [1:0] c);
    return {c, r};
  endfunction

  // Output byte k takes input byte SHIFT_FWD_MAP[k]: row r rotates left by r.
  localparam logic [3:0] SHIFT_FWD_MAP [N_BYTES] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  // Output byte k takes input byte SHIFT_INV_MAP[k]: row r rotates right by r.
  localparam logic [3:0] SHIFT_INV_MAP [N_BYTES] = '{
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

endpackage

// File: rtl/shift_row_perm.sv
// -----------------------------------------------------------------------------
// shift_row_perm
// Purely combinational ShiftRows / InvShiftRows byte permutation. Pure wiring:
// no byte value is modified, so unknown input bytes only affect the output
// byte they are routed to.
//   INVERSE  : 0 = ShiftRows (rotate rows left), 1 = InvShiftRows (right)
//   i_state  : [0:127] AES state, bit 0 = MSB of byte 0
//   o_state  : [0:127] permuted state, same byte order
// -----------------------------------------------------------------------------
module shift_row_perm
  import shift_row_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [0:STATE_W-1] i_state,
  output logic [0:STATE_W-1] o_state
);

  aes_state_t w_in_bytes;
  aes_state_t w_out_bytes;

  genvar gi;
  generate
    for (gi = 0; gi < N_BYTES; gi++) begin : g_byte
      // Source byte resolved at elaboration time; each output byte is a wire.
      localparam int SRC = INVERSE ? int'(SHIFT_INV_MAP[gi]) : int'(SHIFT_FWD_MAP[gi]);

      // Ascending vector: [8k +: 8] is bits 8k..8k+7, with bit 8k the byte MSB.
      assign w_in_bytes[gi]          = i_state[8*gi +: 8];
      assign w_out_bytes[gi]         = w_in_bytes[SRC];
      assign o_state[8*gi +: 8]      = w_out_bytes[gi];
    end
  endgenerate

endmodule

// File: rtl/shift_row.sv
// -----------------------------------------------------------------------------
// shift_row
// AES-128 ShiftRows pipeline stage: byte permutation followed by one register.
// Captures on every rising edge (no enable / valid); validity is tracked by
// the enclosing pipeline.
//   INVERSE  : 0 = ShiftRows, 1 = InvShiftRows
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears dataOut to 0
//   dataIn   : [0:127] AES state, bit 0 = MSB of byte 0
//   dataOut  : [0:127] registered permuted state (1 cycle latency)
// -----------------------------------------------------------------------------
module shift_row
  import shift_row_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:STATE_W-1] dataIn,
  output logic [0:STATE_W-1] dataOut
);

  logic [0:STATE_W-1] w_perm;
  logic [0:STATE_W-1] r_data;

  shift_row_perm #(
    .INVERSE (INVERSE)
  ) u_perm (
    .i_state (dataIn),
    .o_state (w_perm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_perm;
    end
  end

  assign dataOut = r_data;

endmodule

// File: tb/tb_shift_row.sv
// -----------------------------------------------------------------------------
// tb_shift_row
// Forward stage feeds an inverse stage, so the inverse output must return the
// original state two cycles after it entered. Expected forward values come
// from a fixed vector table or from a row/column rotation model.
// -----------------------------------------------------------------------------
module tb_shift_row;

  typedef struct {
    logic [0:127] din;
    logic [0:127] exp;
  } vec_t;

  logic         clk;
  logic         rst;
  logic [0:127] din_fwd;
  logic [0:127] dout_fwd;
  logic [0:127] dout_inv;

  int tests_run;
  int tests_failed;

  // Expected outputs after the next rising edge, and the source of exp_fwd.
  logic [0:127] exp_fwd;
  logic [0:127] exp_inv;
  logic [0:127] cur_src;

  shift_row #(.INVERSE(1'b0)) dut_fwd (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (din_fwd),
    .dataOut (dout_fwd)
  );

  shift_row #(.INVERSE(1'b1)) dut_inv (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (dout_fwd),
    .dataOut (dout_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: output byte (r,c) = input byte (r, (c+r) mod 4).
  function automatic logic [0:127] ref_fwd(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: check outputs from the last edge, then drive the next input
  // and the reset level that the coming edge will see.
  task automatic tick(input string tag, input logic [0:127] din,
                      input logic [0:127] exp, input logic rst_next);
    @(negedge clk);
    check({tag, " fwd"}, dout_fwd, exp_fwd);
    check({tag, " inv"}, dout_inv, exp_inv);
    $display("[TB] %s in=%h fwd=%h inv=%h", tag, din_fwd, dout_fwd, dout_inv);
    rst     = rst_next;
    din_fwd = din;
    if (rst_next) begin
      exp_fwd = '0;
      exp_inv = '0;
      cur_src = '0;
    end else begin
      exp_inv = cur_src;
      cur_src = din;
      exp_fwd = exp;
    end
  endtask

  // Reset pulse strictly between edges: outputs must clear with no clock.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async clear fwd", dout_fwd, 128'h0);
    check("async clear inv", dout_inv, 128'h0);
    #1;
    rst = 1'b0;
    exp_fwd = '0;
    exp_inv = '0;
    cur_src = '0;
  endtask

  vec_t vecs [6];

  initial begin
    logic [0:127] x;
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    din_fwd      = rand_state();
    exp_fwd      = '0;
    exp_inv      = '0;
    cur_src      = '0;

    vecs[0] = '{128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, 128'h632FAFA2EB93C7209F92ABCBA0C0302B};
    vecs[1] = '{128'h6AA0303D594E9CF4CB48989BBD129E8B, 128'h6A4E988B59489E3DCB1230F4BDA09C9B};
    vecs[2] = '{128'h1AB4D3AAAB5BBAE80130E9BB2741D29A, 128'h1A5BE99AAB30D2AA0141D3E827B4BABB};
    vecs[3] = '{128'hBC3804205138FF26EEEB9A39B31218A1, 128'hBC389AA151EB1820EE120426B338FF39};
    vecs[4] = '{128'hC874D15530B020F8F2C8DD66943750B7, 128'hC8B0DDB730C85055F237D1F894742066};
    vecs[5] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00050A0F04090E03080D02070C01060B};

    // Reset asserted from time 0: outputs zero before any clock.
    #1;
    check("reset initial fwd", dout_fwd, 128'h0);
    check("reset initial inv", dout_inv, 128'h0);

    // Edges while in reset must not capture.
    for (int i = 0; i < 3; i++) tick("reset hold", rand_state(), 128'h0, 1'b1);

    // Table vectors back to back; the first edge after release captures.
    for (int i = 0; i < 6; i++) tick($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp, 1'b0);

    // Inverse-specific sequence: 63C0.. goes forward to 632F.., and the
    // inverse stage must return 63C0.. two cycles after entry.
    tick("inv seq a", vecs[0].din, vecs[0].exp, 1'b0);
    tick("inv seq b", 128'h0, 128'h0, 1'b0);
    tick("inv seq c", 128'h0, 128'h0, 1'b0);

    // Random states against the rotation model, with round trip.
    for (int i = 0; i < 1000; i++) begin
      x = rand_state();
      tick($sformatf("rand%0d", i), x, ref_fwd(x), 1'b0);
    end

    // Mid-stream reset discards in-flight data.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      x = rand_state();
      tick($sformatf("post%0d", i), x, ref_fwd(x), 1'b0);
    end
    tick("drain0", 128'h0, 128'h0, 1'b0);
    tick("drain1", 128'h0, 128'h0, 1'b0);
    tick("drain2", 128'h0, 128'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
